// File: rtl/mult_8x8_seq_ctrl.sv
// 8x8 multiply sequencer: time-multiplexes one external 4x4 sub-multiplier
// over four nibble quadrants and shift-accumulates the partial products.
module mult_8x8_seq_ctrl #(
  parameter int SUB_LAT   = 0,   // sub-multiplier latency, 0..3
  parameter bit ZERO_SKIP = 1'b0 // skip quadrants with a zero nibble
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [7:0]  mode,
  output logic [3:0]  sub_a,
  output logic [3:0]  sub_b,
  output logic [1:0]  sub_sel,
  output logic        sub_start,
  input  logic [7:0]  sub_p,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] R
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  a_reg, a_next, b_reg, b_next, mode_reg, mode_next;
  logic [15:0] acc_reg, acc_next, r_reg, r_next;
  logic [3:0]  pend_reg, pend_next;   // quadrants still to issue, incl. current
  logic [1:0]  cnt_reg, cnt_next;     // cycle within the current quadrant
  logic [3:0]  sub_a_reg, sub_a_next, sub_b_reg, sub_b_next;
  logic [1:0]  sub_sel_reg, sub_sel_next;
  logic        sub_start_reg, sub_start_next;

  logic [1:0]  cur_q;
  logic [3:0]  mask;
  logic [3:0]  rem;
  logic [1:0]  nq;
  logic [15:0] sum;

  // Quadrant q uses A nibble q[1] and B nibble q[0].
  function automatic logic [3:0] nib(input logic [7:0] x, input logic hi);
    return hi ? x[7:4] : x[3:0];
  endfunction

  function automatic logic [3:0] issue_mask(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] m;
    m = '0;
    for (int q = 0; q < 4; q++) begin
      m[q] = (ZERO_SKIP == 1'b0) || ((nib(a, q[1]) != 4'd0) && (nib(b, q[0]) != 4'd0));
    end
    return m;
  endfunction

  // Lowest-numbered pending quadrant.
  function automatic logic [1:0] first_q(input logic [3:0] m);
    logic [1:0] f;
    f = 2'd0;
    for (int q = 3; q >= 0; q--) begin
      if (m[q]) f = 2'(q);
    end
    return f;
  endfunction

  function automatic logic [1:0] sel_of(input logic [7:0] md, input logic [1:0] q);
    case (q)
      2'd0:    return md[1:0];
      2'd1:    return md[3:2];
      2'd2:    return md[5:4];
      default: return md[7:6];
    endcase
  endfunction

  function automatic logic [3:0] shift_of(input logic [1:0] q);
    case (q)
      2'd0:    return 4'd0;
      2'd3:    return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  assign cur_q     = first_q(pend_reg);
  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == DONE);
  assign R         = r_reg;
  assign sub_a     = sub_a_reg;
  assign sub_b     = sub_b_reg;
  assign sub_sel   = sub_sel_reg;
  assign sub_start = sub_start_reg;

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_next     = state_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    mode_next      = mode_reg;
    acc_next       = acc_reg;
    r_next         = r_reg;
    pend_next      = pend_reg;
    cnt_next       = cnt_reg;
    sub_a_next     = sub_a_reg;
    sub_b_next     = sub_b_reg;
    sub_sel_next   = sub_sel_reg;
    sub_start_next = 1'b0;
    mask           = '0;
    rem            = '0;
    nq             = '0;
    sum            = '0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = A;
          b_next     = B;
          mode_next  = mode;
          acc_next   = '0;
          cnt_next   = '0;
          mask       = issue_mask(A, B);
          pend_next  = mask;
          state_next = ISSUE;
          // First quadrant goes out on the acceptance edge so every quadrant
          // occupies exactly SUB_LAT+1 cycles.
          if (mask != 4'd0) begin
            nq             = first_q(mask);
            sub_a_next     = nib(A, nq[1]);
            sub_b_next     = nib(B, nq[0]);
            sub_sel_next   = sel_of(mode, nq);
            sub_start_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (pend_reg == 4'd0) begin
          // Nothing was issued: result is the cleared accumulator.
          state_next = DONE;
          r_next     = acc_reg;
        end else if (cnt_reg == 2'(SUB_LAT)) begin
          sum       = acc_reg + ({8'h00, sub_p} << shift_of(cur_q));
          acc_next  = sum;
          rem       = pend_reg & ~(4'b0001 << cur_q);
          pend_next = rem;
          cnt_next  = '0;
          if (rem == 4'd0) begin
            state_next   = DONE;
            r_next       = sum;
            sub_a_next   = '0;
            sub_b_next   = '0;
            sub_sel_next = '0;
          end else begin
            nq             = first_q(rem);
            sub_a_next     = nib(a_reg, nq[1]);
            sub_b_next     = nib(b_reg, nq[0]);
            sub_sel_next   = sel_of(mode_reg, nq);
            sub_start_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      mode_reg      <= '0;
      acc_reg       <= '0;
      r_reg         <= '0;
      pend_reg      <= '0;
      cnt_reg       <= '0;
      sub_a_reg     <= '0;
      sub_b_reg     <= '0;
      sub_sel_reg   <= '0;
      sub_start_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      mode_reg      <= mode_next;
      acc_reg       <= acc_next;
      r_reg         <= r_next;
      pend_reg      <= pend_next;
      cnt_reg       <= cnt_next;
      sub_a_reg     <= sub_a_next;
      sub_b_reg     <= sub_b_next;
      sub_sel_reg   <= sub_sel_next;
      sub_start_reg <= sub_start_next;
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Testbench: three controller instances (SUB_LAT/ZERO_SKIP = 0/0, 2/0, 1/1)
// with a behavioural sub-multiplier responder and an arithmetic reference.
module tb_mult_8x8_seq_ctrl;
  localparam int ND = 3;

  // Responder modes: exact, exact only on the sampling cycle, all 0xFF,
  // and a select-dependent approximate product.
  localparam int PM_EXACT = 0;
  localparam int PM_LATE  = 1;
  localparam int PM_FF    = 2;
  localparam int PM_APPROX = 3;

  logic clk;
  logic rst;
  logic [ND-1:0]    iv, ordy, irdy, ovld, sstart;
  logic [ND*8-1:0]  a_all, b_all, m_all;
  logic [ND*4-1:0]  sa_all, sb_all;
  logic [ND*2-1:0]  ss_all;
  logic [ND*16-1:0] r_all;
  int pmode;
  int n_vec;
  int n_bad;

  typedef struct {
    int          d;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  m;
    int          pm;
    int          hold;
    logic [15:0] exp_r;
    int          exp_lat;
  } vec_t;

  function automatic int lat_of(input int d);
    return (d == 1) ? 2 : ((d == 2) ? 1 : 0);
  endfunction

  function automatic bit zs_of(input int d);
    return d == 2;
  endfunction

  function automatic logic [7:0] approx(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
    logic [7:0] ex;
    ex = {4'b0, a} * {4'b0, b};
    case (s)
      2'd0:    return ex;
      2'd1:    return ex & 8'hF0;
      2'd2:    return ex | 8'h01;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] sub_model(input int pm, input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] s, input int cur, input int lat);
    logic [7:0] ex;
    ex = {4'b0, a} * {4'b0, b};
    case (pm)
      PM_EXACT: return ex;
      PM_LATE:  return (cur == lat) ? ex : 8'hFF;
      PM_FF:    return 8'hFF;
      default:  return approx(a, b, s);
    endcase
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      logic [7:0] sp;
      int pos;
      // Cycle position within the current quadrant, as the external
      // multiplier would see it.
      always @(posedge clk) begin
        if (rst) pos <= 0;
        else     pos <= sstart[gi] ? 1 : pos + 1;
      end
      always_comb sp = sub_model(pmode, sa_all[gi*4 +: 4], sb_all[gi*4 +: 4], ss_all[gi*2 +: 2],
                                 sstart[gi] ? 0 : pos, (gi == 1) ? 2 : ((gi == 2) ? 1 : 0));
      mult_8x8_seq_ctrl #(
        .SUB_LAT  ((gi == 1) ? 2 : ((gi == 2) ? 1 : 0)),
        .ZERO_SKIP((gi == 2) ? 1'b1 : 1'b0)
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (iv[gi]),
        .in_ready (irdy[gi]),
        .A        (a_all[gi*8 +: 8]),
        .B        (b_all[gi*8 +: 8]),
        .mode     (m_all[gi*8 +: 8]),
        .sub_a    (sa_all[gi*4 +: 4]),
        .sub_b    (sb_all[gi*4 +: 4]),
        .sub_sel  (ss_all[gi*2 +: 2]),
        .sub_start(sstart[gi]),
        .sub_p    (sp),
        .out_valid(ovld[gi]),
        .out_ready(ordy[gi]),
        .R        (r_all[gi*16 +: 16])
      );
    end
  endgenerate

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: expected result and latency from the quadrant rules.
  task automatic model(input int d, input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input int pm, output logic [15:0] r, output int lat);
    int n;
    logic [3:0] an, bn;
    n = 0;
    r = '0;
    for (int q = 0; q < 4; q++) begin
      an = q[1] ? a[7:4] : a[3:0];
      bn = q[0] ? b[7:4] : b[3:0];
      if (!zs_of(d) || (an != 0 && bn != 0)) begin
        n++;
        if (pm == PM_APPROX)
          r = r + (16'(approx(an, bn, 2'(m >> (2 * q)))) << (4 * (q[0] + q[1])));
      end
    end
    if (pm != PM_APPROX) r = 16'(a) * 16'(b);
    lat = (n == 0) ? 1 : n * (lat_of(d) + 1);
  endtask

  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        input int pm, input int hold, input logic [15:0] exp_r, input int exp_lat);
    int w, lat, idx;
    logic [3:0] an, bn;
    logic [9:0] exp_tr [4];
    int n_exp;
    string tag;
    tag = $sformatf("d%0d A=%02h B=%02h M=%02h", d, a, b, m);
    n_exp = 0;
    for (int q = 0; q < 4; q++) begin
      an = q[1] ? a[7:4] : a[3:0];
      bn = q[0] ? b[7:4] : b[3:0];
      if (!zs_of(d) || (an != 0 && bn != 0)) begin
        exp_tr[n_exp] = {an, bn, 2'(m >> (2 * q))};
        n_exp++;
      end
    end
    pmode = pm;
    w = 0;
    @(negedge clk);
    while (!irdy[d] && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " in_ready"}, 32'(irdy[d]), 32'd1);
    iv[d] = 1'b1;
    a_all[d*8 +: 8] = a;
    b_all[d*8 +: 8] = b;
    m_all[d*8 +: 8] = m;
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    a_all[d*8 +: 8] = 8'($urandom);
    lat = 0;
    idx = 0;
    while (lat < 200) begin
      if (sstart[d]) begin
        if (idx < n_exp)
          chk({tag, " issue"}, 32'({sa_all[d*4 +: 4], sb_all[d*4 +: 4], ss_all[d*2 +: 2]}), 32'(exp_tr[idx]));
        idx++;
      end
      if (ovld[d]) break;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " quadrants"}, 32'(idx), 32'(n_exp));
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " R"}, 32'(r_all[d*16 +: 16]), 32'(exp_r));
    $display("op %s pm=%0d R=%04h lat=%0d", tag, pm, r_all[d*16 +: 16], lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " hold valid"}, 32'(ovld[d]), 32'd1);
      chk({tag, " hold R"}, 32'(r_all[d*16 +: 16]), 32'(exp_r));
      chk({tag, " hold in_ready"}, 32'(irdy[d]), 32'd0);
    end
    ordy[d] = 1'b1;
    @(posedge clk);
    #1;
    ordy[d] = 1'b0;
    chk({tag, " valid drop"}, 32'(ovld[d]), 32'd0);
    chk({tag, " ready back"}, 32'(irdy[d]), 32'd1);
  endtask

  vec_t vecs [6];

  initial begin
    logic [7:0] ra, rb, rm;
    logic [15:0] er;
    int el, d, pm;
    n_vec = 0;
    n_bad = 0;
    pmode = PM_EXACT;
    iv = '0;
    ordy = '0;
    a_all = '0;
    b_all = '0;
    m_all = '0;

    vecs[0] = '{0, 8'hB7, 8'h5C, 8'hE4, PM_EXACT, 5, 16'h41C4, 4};
    vecs[1] = '{1, 8'hB7, 8'h5C, 8'hE4, PM_LATE,  0, 16'h41C4, 12};
    vecs[2] = '{2, 8'h0F, 8'h30, 8'h1B, PM_EXACT, 0, 16'h02D0, 2};
    vecs[3] = '{2, 8'h00, 8'h5C, 8'h00, PM_EXACT, 1, 16'h0000, 1};
    vecs[4] = '{0, 8'hB7, 8'h5C, 8'h00, PM_FF,    0, 16'h1FDF, 4};
    vecs[5] = '{1, 8'hFF, 8'hFF, 8'h00, PM_EXACT, 0, 16'hFE01, 12};

    // Reset held three cycles with in_valid asserted.
    rst = 1'b1;
    iv = '1;
    a_all = '1;
    b_all = '1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset R", 32'(r_all[15:0]), 32'd0);
      chk("reset out_valid", 32'(ovld), 32'd0);
      chk("reset sub", 32'({sa_all[3:0], sb_all[3:0], ss_all[1:0], sstart[0]}), 32'd0);
      chk("reset in_ready", 32'(irdy), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    iv = '0;
    #1;
    chk("post-reset in_ready", 32'(irdy), 32'h7);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].pm, vecs[i].hold,
             vecs[i].exp_r, vecs[i].exp_lat);
    end

    // Reset in the middle of quadrant 2 abandons the operation.
    pmode = PM_EXACT;
    @(negedge clk);
    iv[0] = 1'b1;
    a_all[7:0] = 8'h5A;
    b_all[7:0] = 8'hC3;
    m_all[7:0] = 8'h00;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midrst q2 operands", 32'({sa_all[3:0], sb_all[3:0]}), 32'h53);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("midrst out_valid", 32'(ovld[0]), 32'd0);
    end
    chk("midrst R", 32'(r_all[15:0]), 32'd0);
    run_op(0, 8'h02, 8'h03, 8'h00, PM_EXACT, 0, 16'h0006, 4);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      d  = $urandom_range(0, ND - 1);
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ra = ra & 8'hF0;
      if ($urandom_range(0, 3) == 0) rb = rb & 8'h0F;
      if ($urandom_range(0, 7) == 0) ra = 8'h00;
      pm = ($urandom_range(0, 1) == 0) ? PM_EXACT : PM_APPROX;
      model(d, ra, rb, rm, pm, er, el);
      run_op(d, ra, rb, rm, pm, $urandom_range(0, 2), er, el);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
